// File: rtl/rr_arb4_pkg.sv
// Shared types and helpers for the four-channel round-robin stream arbiter.
package rr_arb4_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic {
      StIdle = 1'b0,
      StLock = 1'b1
   } state_e;

   // First requesting channel scanning ptr, ptr+1, ... with 2-bit wraparound.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [SEL_W-1:0]  ptr);
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] win;
      logic             found;
      win   = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = ptr + SEL_W'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_stream_arb4_if.sv
// Handshake bundle between four packet sources, the arbiter and the downstream sink.
interface rr_stream_arb4_if #(
   parameter int unsigned DATA_W = 8
);
   import rr_arb4_pkg::*;

   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_last;
   logic [NUM_CH-1:0]        in_ready;
   logic [SEL_W-1:0]         sel;
   logic [NUM_CH-1:0]        grant;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;
   logic                     out_ready;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, sel, grant, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, sel, grant, out_valid, out_data, out_last
   );

endinterface

// File: rtl/mux_4to1.sv
// Plain 4:1 multiplexer; the arbiter feeds it {last,data} per channel.
module mux_4to1 #(
   parameter int unsigned WIDTH = 9
) (
   input  logic [4*WIDTH-1:0] din,
   input  logic [1:0]         sel,
   output logic [WIDTH-1:0]   dout
);

   always_comb begin
      dout = '0;
      unique case (sel)
         2'd0: dout = din[0*WIDTH +: WIDTH];
         2'd1: dout = din[1*WIDTH +: WIDTH];
         2'd2: dout = din[2*WIDTH +: WIDTH];
         2'd3: dout = din[3*WIDTH +: WIDTH];
         default: dout = '0;
      endcase
   end

endmodule

// File: rtl/rr_stream_arb4.sv
// Packet-locked round-robin arbiter over four streams with a registered output slice.
module rr_stream_arb4
   import rr_arb4_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   rr_stream_arb4_if.slave bus
);

   localparam int unsigned BEAT_W = DATA_W + 1;

   state_e                   state_q, state_d;
   logic [SEL_W-1:0]         sel_q, sel_d;
   logic [SEL_W-1:0]         ptr_q, ptr_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [DATA_W-1:0]        out_data_q, out_data_d;
   logic [NUM_CH*BEAT_W-1:0] mux_in;
   logic [BEAT_W-1:0]        mux_out;
   logic                     slot_free;
   logic                     xfer;

   always_comb begin
      mux_in = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         mux_in[k*BEAT_W +: BEAT_W] = {bus.in_last[k], bus.in_data[k*DATA_W +: DATA_W]};
      end
   end

   mux_4to1 #(
      .WIDTH (BEAT_W)
   ) u_mux (
      .din  (mux_in),
      .sel  (sel_q),
      .dout (mux_out)
   );

   // The slice can take a beat when empty or draining this cycle.
   assign slot_free = !out_valid_q || bus.out_ready;
   assign xfer      = (state_q == StLock) && bus.in_valid[sel_q] && slot_free;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      ptr_d        = ptr_q;
      bus.in_ready = '0;
      bus.grant    = '0;
      unique case (state_q)
         StIdle: begin
            if (|bus.in_valid) begin
               state_d = StLock;
               sel_d   = rr_pick(bus.in_valid, ptr_q);
            end
         end
         StLock: begin
            bus.grant[sel_q]    = 1'b1;
            bus.in_ready[sel_q] = slot_free;
            if (xfer && mux_out[DATA_W]) begin
               state_d = StIdle;
               ptr_d   = sel_q + SEL_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_out[DATA_W-1:0];
         out_last_d  = mux_out[DATA_W];
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rr_stream_arb4.sv
// Directed bench for rr_stream_arb4: arbitration order, packet lock, backpressure, reset.
module tb_rr_stream_arb4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   rr_stream_arb4_if #(.DATA_W(8)) bus ();

   rr_stream_arb4 #(
      .DATA_W (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic v, input logic [7:0] d, input logic l);
      bus.in_valid[k]     = v;
      bus.in_data[k*8 +: 8] = d;
      bus.in_last[k]      = l;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.in_last   = '0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 8'(8'hA0 + k), 1'b1);
      tick();
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", bus.grant); end
      total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready got=%b want=0000", bus.in_ready); end
      total++; if (bus.sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", bus.sel); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
      total++; if ({bus.out_last, bus.out_data} !== 9'h000) begin bad++; $display("FAIL rst_out_data got=%h want=000", {bus.out_last, bus.out_data}); end
      rst_n = 1'b1;
      #1;
      total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL idle_in_ready got=%b want=0000", bus.in_ready); end
   endtask

   task automatic test_round_robin();
      int          order [5] = '{0, 1, 2, 3, 0};
      logic [3:0]  exp_g;
      logic [7:0]  exp_d;
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << order[i];
         exp_d = 8'(8'hA0 + order[i]);
         tick();
         total++; if (bus.grant !== exp_g) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", i, bus.grant, exp_g); end
         total++; if (bus.in_ready !== exp_g) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b want=%b", i, bus.in_ready, exp_g); end
         total++; if (bus.sel !== 2'(order[i])) begin bad++; $display("FAIL rr_sel[%0d] got=%0d want=%0d", i, bus.sel, order[i]); end
         tick();
         total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rr_bubble[%0d] got=%b want=0000", i, bus.grant); end
         total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin bad++; $display("FAIL rr_beat[%0d] got=%b/%h want=1/%h", i, bus.out_valid, bus.out_data, exp_d); end
      end
      bus.in_valid = '0;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_packet_lock();
      set_ch(2, 1'b1, 8'hA1, 1'b0);
      tick();
      total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL lock_grant got=%b want=0100", bus.grant); end
      set_ch(0, 1'b1, 8'hC0, 1'b1);
      set_ch(1, 1'b1, 8'hB1, 1'b0);
      tick();
      total++; if (bus.out_data !== 8'hA1 || bus.out_last !== 1'b0) begin bad++; $display("FAIL lock_a1 got=%h/%b want=a1/0", bus.out_data, bus.out_last); end
      total++; if (bus.in_ready !== 4'b0100 || bus.grant !== 4'b0100) begin bad++; $display("FAIL lock_held got=%b/%b want=0100/0100", bus.in_ready, bus.grant); end
      set_ch(2, 1'b1, 8'hA2, 1'b0);
      tick();
      total++; if (bus.out_data !== 8'hA2 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL lock_a2 got=%h/%b want=a2/1", bus.out_data, bus.out_valid); end
      set_ch(2, 1'b1, 8'hA3, 1'b1);
      tick();
      total++; if (bus.out_data !== 8'hA3 || bus.out_last !== 1'b1) begin bad++; $display("FAIL lock_a3 got=%h/%b want=a3/1", bus.out_data, bus.out_last); end
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL lock_release got=%b want=0000", bus.grant); end
      set_ch(2, 1'b0, 8'h00, 1'b0);
      tick();
      total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL lock_next_grant got=%b want=0001", bus.grant); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lock_drain got=%b want=0", bus.out_valid); end
      tick();
      total++; if (bus.out_data !== 8'hC0 || bus.out_last !== 1'b1) begin bad++; $display("FAIL lock_c0 got=%h/%b want=c0/1", bus.out_data, bus.out_last); end
      set_ch(0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_backpressure();
      tick();
      total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b want=0010", bus.grant); end
      tick();
      total++; if (bus.out_data !== 8'hB1 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_b1 got=%h/%b want=b1/1", bus.out_data, bus.out_valid); end
      set_ch(1, 1'b1, 8'hB2, 1'b0);
      bus.out_ready = 1'b0;
      #1;
      total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready got=%b want=0000", bus.in_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (bus.out_data !== 8'hB1 || bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b/%b want=b1/1/0000", i, bus.out_data, bus.out_valid, bus.in_ready); end
      end
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.in_ready !== 4'b0010) begin bad++; $display("FAIL bp_resume_ready got=%b want=0010", bus.in_ready); end
      tick();
      total++; if (bus.out_data !== 8'hB2 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_b2 got=%h/%b want=b2/1", bus.out_data, bus.out_valid); end
      set_ch(1, 1'b1, 8'hB3, 1'b0);
      tick();
      total++; if (bus.out_data !== 8'hB3) begin bad++; $display("FAIL bp_b3 got=%h want=b3", bus.out_data); end
      set_ch(1, 1'b1, 8'hB4, 1'b1);
      tick();
      total++; if (bus.out_data !== 8'hB4 || bus.out_last !== 1'b1 || bus.grant !== 4'b0000) begin bad++; $display("FAIL bp_b4 got=%h/%b/%b want=b4/1/0000", bus.out_data, bus.out_last, bus.grant); end
      set_ch(1, 1'b0, 8'h00, 1'b0);
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_wrap();
      set_ch(2, 1'b1, 8'h2C, 1'b1);
      tick();
      total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL wrap_pre_grant got=%b want=0100", bus.grant); end
      tick();
      total++; if (bus.out_data !== 8'h2C) begin bad++; $display("FAIL wrap_pre_beat got=%h want=2c", bus.out_data); end
      set_ch(2, 1'b0, 8'h00, 1'b0);
      set_ch(3, 1'b1, 8'h3D, 1'b1);
      set_ch(1, 1'b1, 8'h1D, 1'b1);
      tick();
      total++; if (bus.grant !== 4'b1000 || bus.sel !== 2'd3) begin bad++; $display("FAIL wrap_ch3 got=%b/%0d want=1000/3", bus.grant, bus.sel); end
      tick();
      total++; if (bus.out_data !== 8'h3D) begin bad++; $display("FAIL wrap_ch3_beat got=%h want=3d", bus.out_data); end
      set_ch(3, 1'b0, 8'h00, 1'b0);
      tick();
      total++; if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin bad++; $display("FAIL wrap_ch1 got=%b/%0d want=0010/1", bus.grant, bus.sel); end
      tick();
      total++; if (bus.out_data !== 8'h1D) begin bad++; $display("FAIL wrap_ch1_beat got=%h want=1d", bus.out_data); end
      set_ch(1, 1'b0, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_mid_reset();
      set_ch(1, 1'b1, 8'hE1, 1'b0);
      tick();
      total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL mrst_lock got=%b want=0010", bus.grant); end
      set_ch(3, 1'b1, 8'h3E, 1'b1);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE1) begin bad++; $display("FAIL mrst_beat got=%b/%h want=1/e1", bus.out_valid, bus.out_data); end
      rst_n = 1'b0;
      #1;
      total++; if (bus.grant !== 4'b0000 || bus.in_ready !== 4'b0000) begin bad++; $display("FAIL mrst_drop got=%b/%b want=0000/0000", bus.grant, bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0 || bus.sel !== 2'd0) begin bad++; $display("FAIL mrst_clear got=%b/%0d want=0/0", bus.out_valid, bus.sel); end
      #2;
      rst_n = 1'b1;
      tick();
      total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL mrst_regrant got=%b want=0010", bus.grant); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_backpressure();
      test_wrap();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_stream_arb4.md
# rr_stream_arb4

Round-robin arbiter and output stage for four packet streams. It sits directly upstream of the team's 4:1 multiplexer: it decides which channel owns the output, drives the mux select, and handshakes beats through a registered output slice. Grants lock for a whole packet (terminated by `last`), so packets from different channels never interleave.

## Interface
- `DATA_W`, default 8: payload width per channel.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  4  per-channel beat valid.
- `in_data`  in  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- `in_last`  in  4  per-channel end-of-packet flag.
- `in_ready`  out  4  per-channel accept; at most one bit high.
- `sel`  out  2  mux select = index of locked channel.
- `grant`  out  4  one-hot grant; all zero in IDLE.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  DATA_W  registered payload.
- `out_last`  out  1  registered end-of-packet.
- `out_ready`  in  1  downstream accept.

## Operation
- States: IDLE, LOCK. Registered state: `state`, `sel`, `ptr[1:0]` (highest-priority channel), output slice.
- IDLE: if any `in_valid`, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); next cycle `state`=LOCK, `sel`=winner, `grant`=one-hot(winner). No valid: stay IDLE.
- LOCK: `in_ready[sel]` = !out_valid || out_ready; all other `in_ready` bits 0. `in_ready` is 0 in IDLE.
- Transfer on channel sel = in_valid[sel] && in_ready[sel]: load out_data/out_last from channel sel via the 4:1 mux, out_valid<=1.
- Output slice: out_valid clears when out_valid && out_ready and no new transfer in that cycle; a simultaneous drain and load keeps out_valid=1 with new data.
- Transfer with in_last[sel]=1: next state IDLE, ptr<=sel+1 (mod 4, 3 wraps to 0), grant cleared.
- Sources hold valid/data/last stable until accepted. A valid drop mid-packet leaves the lock held; there is no timeout.
- Requests from non-granted channels never affect a locked packet.

## Timing
- Reset values: state IDLE, sel 0, grant 0, ptr 0, in_ready 0, out_valid 0, out_data 0, out_last 0.
- Arbitration latency: 1 cycle from in_valid (IDLE) to grant/in_ready.
- Beat latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle within a packet with out_ready held high.
- One IDLE bubble cycle between consecutive packets, including same-channel back-to-back packets.
- in_ready depends combinationally on out_ready; there is no other input-to-output combinational path.
- Reset asserted mid-packet: all state is cleared immediately and the in-flight beat is lost. After release, arbitration restarts with ptr=0.

## Structure
- Shared package `rr_arb4_pkg`: NUM_CH=4, SEL_W=2, state encoding IDLE=1'b0 / LOCK=1'b1, and a rotate-priority function for the winner scan.
- Sub-module: `mux_4to1`, a parameterised DATA_W+1 bit 4:1 mux selecting {last,data} by `sel`. This is the downstream stage and is instantiated once.
- The top holds the FSM, pointer and output slice.

## Test plan
- Reset: rst_n=0 mid-stream, then release → all outputs 0, first grant goes to channel 0 when in_valid=4'b1111.
- Round robin: in_valid=4'b1111, single-beat packets each, out_ready=1 → grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Packet lock: ch2 sends 3 beats A1,A2,A3 (last on A3) while ch0/ch1 request → out_data A1,A2,A3 contiguous, then grant ch3 is skipped if idle and ch0 is granted.
- Backpressure: out_ready=0 for 4 cycles mid-packet → out_data held stable, in_ready[sel]=0, no beat lost or duplicated; resume yields 1 beat/cycle.
- Wrap: ptr=3, only ch3 and ch1 valid → ch3 granted, then ch1 (ptr wraps 3→0).
- Mid-packet async reset while ch1 is locked → in_ready/grant drop the same cycle, out_valid=0, next grant decided fresh from ptr=0.
